packet_arbiter_rr: RTL and testbench
====================================

# packet_arbiter_rr

Output-side merge stage of the NoC router. Collects AXI-Stream packets from `CHANNEL_NUMBER` input-side routing stages that target the same physical output and forwards them onto one output link. A round-robin arbiter grants one input at a time and holds the lock from the routing-header beat through the `TLAST` beat. No flits from different packets ever interleave on the output.

## Interface
Parameters:
- `AXIS_DATA_WIDTH`, 40: `TDATA` width inside `axis_mosi_t`.
- `ID_WIDTH`, 4: `TID` width; `TID == ROUTING_HEADER` marks a header beat.
- `CHANNEL_NUMBER`, 5: number of competing inputs; must be ≥ 2.
- `CHANNEL_NUMBER_WIDTH`, `$clog2(CHANNEL_NUMBER)`: width of the grant index.

Ports (one clock; reset is asynchronous and active-high):
- `clk_i`, input, 1: clock; all state updates on the rising edge.
- `rst_i`, input, 1: asynchronous active-high reset.
- `in_mosi_i[CHANNEL_NUMBER]`, input, `axis_mosi_t`: per-input `TVALID` and data.
- `in_miso_o[CHANNEL_NUMBER]`, output, `axis_miso_t`: per-input `TREADY`.
- `out_mosi_o`, output, `axis_mosi_t`: merged output stream.
- `out_miso_i`, input, `axis_miso_t`: output `TREADY`.
- `current_grant_o`, output, `CHANNEL_NUMBER_WIDTH`: locked input index; meaningful only while `grant_valid_o` is 1.
- `grant_valid_o`, output, 1: high while in LOCKED.
- `proto_err_o`, output, 1: sticky; set when a non-header beat is valid on an input in IDLE.

## Operation
- **States:** IDLE and LOCKED. Registers: `rr_ptr`, `grant_q`, `proto_err`.
- **IDLE arbitration.**
  - Requesting inputs are those with `TVALID=1` and `TID == ROUTING_HEADER`.
  - Scan starts at `rr_ptr` and wraps modulo `CHANNEL_NUMBER`; the first requester wins.
  - The winner is registered into `grant_q` and the state moves to LOCKED.
  - While in IDLE, every `TREADY` is 0 and `out_mosi_o` is all-zero.
- **LOCKED.**
  - `out_mosi_o = in_mosi_i[grant_q]`.
  - `in_miso_o[grant_q] = out_miso_i`; all other `TREADY` are 0 and their inputs are untouched.
- **Packet end.** When a beat with `TLAST=1` is accepted (output `TVALID & TREADY`):
  - next state is IDLE;
  - `rr_ptr = (grant_q + 1) mod CHANNEL_NUMBER`; the wrap from `CHANNEL_NUMBER-1` goes to 0.
- **Single-beat packets.** A header with `TLAST=1` is legal: one accepted beat, then IDLE.
- **Protocol error.** A valid non-header beat on any input while in IDLE is never granted: it stays stalled (`TREADY=0`) and `proto_err` is set. `proto_err` clears only on reset.
- **Simultaneous events.** A `TLAST` acceptance and new requests in the same cycle: the new requests are arbitrated on the following cycle from IDLE using the updated `rr_ptr`.
- **Reset mid-packet.** The lock is dropped and the state returns to IDLE. Downstream sees a truncated packet; upper layers handle recovery.

## Timing
- **Reset values:**
  - state IDLE, `rr_ptr=0`, `grant_q=0`, `proto_err=0`;
  - `out_mosi_o` all-zero, every `in_miso_o.TREADY=0`;
  - `grant_valid_o=0`, `current_grant_o=0`, `proto_err_o=0`.
- **Arbitration latency:** exactly 1 cycle. A header valid at cycle N is presented on the output at N+1 when `OUTPUT_REG_EN` is undefined.
- **Throughput:** one beat per cycle while LOCKED. There is one idle bubble cycle between consecutive packets.
- **Output handshake:**
  - `TVALID` on the output never drops while `TREADY=0`;
  - data stays stable, because the grant cannot change before `TLAST` is accepted.
- **Without the macro:** the path from `out_miso_i.TREADY` to `in_miso_o` is purely combinational.

## Configuration
- **`PACKET_ARBITER_OUTPUT_REG_EN` defined:** an `axis_skid_buffer` is inserted between the mux and `out_mosi_o`/`out_miso_i`.
  - Output data and `TVALID` are registered; `TREADY` toward the mux comes from the buffer.
  - Latency becomes 2 cycles from header valid to output valid.
  - Full throughput is kept.
  - LOCKED ends when `TLAST` is accepted by the skid buffer, not by the output.
  - The buffer resets empty.
- **Undefined:** direct combinational connection as described above.

## Structure
- **Shared package `noc_axis_pkg`:** `axis_mosi_t`, `axis_miso_t`, the `ROUTING_HEADER` constant.
- **Local to the module:** the state enum (IDLE, LOCKED).
- **Round-robin selector:** an inline function.
- **Sub-module:** `axis_skid_buffer`, parameterised by `axis_mosi_t`, instantiated only under `PACKET_ARBITER_OUTPUT_REG_EN`.

## Test plan
1. Single requester: input 2 sends header + 3 beats + `TLAST`, output `TREADY=1`.
   - Output beats appear on cycles N+1 to N+4.
   - `current_grant_o=2`, `grant_valid_o=1` throughout.
   - IDLE at N+5; `rr_ptr=3`.
2. All 5 inputs request continuously with 2-beat packets:
   - grant order is 0,1,2,3,4,0;
   - one bubble cycle between packets;
   - no interleaving.
3. Backpressure: output `TREADY` toggles 1,0,0,1 mid-packet.
   - Output data and `TVALID` are held stable during stalls.
   - A new header on input 3 is not granted until `TLAST` is accepted.
4. Wrap-around: `rr_ptr=4` after a packet from input 3; inputs 0 and 4 request together.
   - Input 4 wins; the next winner is input 0.
5. Protocol error: input 1 presents `TID != ROUTING_HEADER` in IDLE.
   - `TREADY[1]` stays 0; `proto_err_o` rises the next cycle and stays high until `rst_i`.
6. Reset mid-packet: assert `rst_i` after 2 of 4 beats.
   - All outputs return to reset values asynchronously.
   - After release, a fresh header from input 0 is granted normally.

Source files
------------

// File: rtl/noc_axis_pkg.sv
// Shared AXI-Stream types for the NoC router datapath.
package noc_axis_pkg;

  localparam int unsigned AXIS_TDATA_W = 40;
  localparam int unsigned AXIS_TID_W   = 4;

  // TID value that marks the first (routing-header) beat of a packet.
  localparam logic [AXIS_TID_W-1:0] ROUTING_HEADER = 4'hA;

  typedef struct packed {
    logic                    tvalid;
    logic [AXIS_TDATA_W-1:0] tdata;
    logic [AXIS_TID_W-1:0]   tid;
    logic                    tlast;
  } axis_mosi_t;

  typedef struct packed {
    logic tready;
  } axis_miso_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer: registered valid/data, full throughput, ready
// toward the source depends only on local state.
// Compiled only when PACKET_ARBITER_OUTPUT_REG_EN is defined, since the
// arbiter is its sole user.
`ifdef PACKET_ARBITER_OUTPUT_REG_EN
module axis_skid_buffer #(
  parameter type data_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  in_valid_i,
  input  data_t in_data_i,
  output logic  in_ready_o,
  output logic  out_valid_o,
  output data_t out_data_o,
  input  logic  out_ready_i
);

  logic  out_valid_q;
  data_t out_data_q;
  logic  skid_valid_q;
  data_t skid_data_q;

  // Ready only while the spill slot is empty, so no combinational path from out_ready_i.
  assign in_ready_o  = !skid_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  // Output register refills from the spill slot first, else from the input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else if (out_ready_i || !out_valid_q) begin
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= skid_data_q;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= in_valid_i;
        out_data_q  <= in_data_i;
      end
    end else if (in_valid_i && !skid_valid_q) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= in_data_i;
    end
  end

endmodule
`endif

// File: rtl/packet_arbiter_rr.sv
// Round-robin packet merge: locks one input from header beat to TLAST so
// packets never interleave on the output link.
// Option: PACKET_ARBITER_OUTPUT_REG_EN inserts axis_skid_buffer on the output.
module packet_arbiter_rr
  import noc_axis_pkg::*;
#(
  parameter int unsigned AXIS_DATA_WIDTH      = AXIS_TDATA_W,
  parameter int unsigned ID_WIDTH             = AXIS_TID_W,
  parameter int unsigned CHANNEL_NUMBER       = 5,
  parameter int unsigned CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  axis_mosi_t                      in_mosi_i [CHANNEL_NUMBER],
  output axis_miso_t                      in_miso_o [CHANNEL_NUMBER],
  output axis_mosi_t                      out_mosi_o,
  input  axis_miso_t                      out_miso_i,
  output logic [CHANNEL_NUMBER_WIDTH-1:0] current_grant_o,
  output logic                            grant_valid_o,
  output logic                            proto_err_o
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  localparam logic [CHANNEL_NUMBER_WIDTH-1:0] LastCh = CHANNEL_NUMBER_WIDTH'(CHANNEL_NUMBER - 1);

  // The struct widths live in the package; the parameters exist for legacy
  // callers and must agree with it.
  if (AXIS_DATA_WIDTH != AXIS_TDATA_W || ID_WIDTH != AXIS_TID_W || CHANNEL_NUMBER < 2 ||
      CHANNEL_NUMBER_WIDTH < $clog2(CHANNEL_NUMBER)) begin : g_bad_params
    $error("packet_arbiter_rr: parameters inconsistent with noc_axis_pkg");
  end

  // First requester at or after ptr, wrapping modulo CHANNEL_NUMBER.
  function automatic logic [CHANNEL_NUMBER_WIDTH-1:0] rr_pick(
    input logic [CHANNEL_NUMBER-1:0]       req,
    input logic [CHANNEL_NUMBER_WIDTH-1:0] ptr
  );
    logic [CHANNEL_NUMBER_WIDTH-1:0] pick;
    logic [CHANNEL_NUMBER_WIDTH-1:0] cand;
    logic                            found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < CHANNEL_NUMBER; i++) begin
      cand = CHANNEL_NUMBER_WIDTH'((32'(ptr) + i) % CHANNEL_NUMBER);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    return pick;
  endfunction

  logic [0:0]                      state_q, state_d;
  logic [CHANNEL_NUMBER_WIDTH-1:0] grant_q, grant_d;
  logic [CHANNEL_NUMBER_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic                            proto_err_q, proto_err_d;

  logic [CHANNEL_NUMBER-1:0] req;
  logic [CHANNEL_NUMBER-1:0] bad_beat;
  axis_mosi_t                mux_mosi;
  logic                      mux_tready;
  logic                      locked;
  logic                      last_accept;

  assign locked = (state_q == StLocked);

  for (genvar g = 0; g < CHANNEL_NUMBER; g++) begin : g_ch
    assign req[g]      = in_mosi_i[g].tvalid && (in_mosi_i[g].tid == ROUTING_HEADER);
    assign bad_beat[g] = in_mosi_i[g].tvalid && (in_mosi_i[g].tid != ROUTING_HEADER);
    assign in_miso_o[g] = axis_miso_t'{
      tready: locked && (grant_q == CHANNEL_NUMBER_WIDTH'(g)) && mux_tready
    };
  end

  // Forward only the locked input; output is all-zero while idle.
  always_comb begin
    mux_mosi = '0;
    if (locked) begin
      mux_mosi = in_mosi_i[grant_q];
    end
  end

  assign last_accept = locked && mux_mosi.tvalid && mux_tready && mux_mosi.tlast;

`ifdef PACKET_ARBITER_OUTPUT_REG_EN
  logic       skid_valid;
  axis_mosi_t skid_data;

  axis_skid_buffer #(
    .data_t(axis_mosi_t)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (mux_mosi.tvalid),
    .in_data_i  (mux_mosi),
    .in_ready_o (mux_tready),
    .out_valid_o(skid_valid),
    .out_data_o (skid_data),
    .out_ready_i(out_miso_i.tready)
  );

  assign out_mosi_o = skid_valid ? skid_data : '0;
`else
  assign mux_tready = out_miso_i.tready;
  assign out_mosi_o = mux_mosi;
`endif

  // Arbitrate in idle, release the lock and advance the pointer on TLAST acceptance.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    proto_err_d = proto_err_q | ((state_q == StIdle) && (|bad_beat));
    case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StLocked;
          grant_d = rr_pick(req, rr_ptr_q);
        end
      end
      StLocked: begin
        if (last_accept) begin
          state_d  = StIdle;
          rr_ptr_d = (grant_q == LastCh) ? '0 : grant_q + CHANNEL_NUMBER_WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset drops any lock in progress.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign current_grant_o = grant_q;
  assign grant_valid_o   = locked;
  assign proto_err_o     = proto_err_q;

endmodule

// File: tb/tb_packet_arbiter_rr.sv
// Directed bench for packet_arbiter_rr in its default (unregistered) build.
module tb_packet_arbiter_rr;
  import noc_axis_pkg::*;

  localparam int unsigned NCH = 5;
  localparam int unsigned GW  = 3;

  logic            clk_i;
  logic            rst_i;
  axis_mosi_t      in_mosi [NCH];
  axis_miso_t      in_miso [NCH];
  axis_mosi_t      out_mosi;
  axis_miso_t      out_miso;
  logic [GW-1:0]   current_grant;
  logic            grant_valid;
  logic            proto_err;

  int checks = 0;
  int errors = 0;

  packet_arbiter_rr #(
    .CHANNEL_NUMBER(NCH)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .in_mosi_i      (in_mosi),
    .in_miso_o      (in_miso),
    .out_mosi_o     (out_mosi),
    .out_miso_i     (out_miso),
    .current_grant_o(current_grant),
    .grant_valid_o  (grant_valid),
    .proto_err_o    (proto_err)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic axis_mosi_t beat(input int ch, input int k, input logic last);
    axis_mosi_t b;
    b            = '0;
    b.tvalid     = 1'b1;
    b.tdata[15:0] = 16'(ch * 16 + k);
    b.tid        = (k == 0) ? ROUTING_HEADER : 4'h0;
    b.tlast      = last;
    return b;
  endfunction

  function automatic logic [NCH-1:0] rdy_vec();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = in_miso[i].tready;
    return v;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < NCH; i++) in_mosi[i] = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    out_miso.tready = 1'b1;
    clear_inputs();
    step();
    checks++; if (out_mosi !== '0) begin errors++; $display("FAIL reset_out_mosi: got %h want 0", out_mosi); end
    checks++; if (rdy_vec() !== '0) begin errors++; $display("FAIL reset_tready: got %b want 00000", rdy_vec()); end
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_grant_valid: got %b want 0", grant_valid); end
    checks++; if (current_grant !== '0) begin errors++; $display("FAIL reset_grant: got %0d want 0", current_grant); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
    rst_i = 1'b0;
  endtask

  task automatic test_single();
    axis_mosi_t exp;
    apply_reset();
    in_mosi[2] = beat(2, 0, 1'b0);
    #1;
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL single_pre_grant: got %b want 0", grant_valid); end
    checks++; if (rdy_vec() !== '0) begin errors++; $display("FAIL single_pre_tready: got %b want 00000", rdy_vec()); end
    step();
    for (int k = 0; k < 4; k++) begin
      exp = beat(2, k, (k == 3));
      in_mosi[2] = exp;
      #1;
      checks++; if (out_mosi !== exp) begin errors++; $display("FAIL single_beat%0d: got %h want %h", k, out_mosi, exp); end
      checks++; if (current_grant !== 3'd2 || grant_valid !== 1'b1) begin
        errors++; $display("FAIL single_grant%0d: got %0d/%b want 2/1", k, current_grant, grant_valid); end
      checks++; if (rdy_vec() !== 5'b00100) begin errors++; $display("FAIL single_tready%0d: got %b want 00100", k, rdy_vec()); end
      step();
    end
    in_mosi[2] = '0;
    #1;
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL single_idle_after: got %b want 0", grant_valid); end
    // Pointer now 3: inputs 1 and 4 together must grant 4 first, then 1.
    in_mosi[1] = beat(1, 0, 1'b1);
    in_mosi[4] = beat(4, 0, 1'b1);
    step();
    checks++; if (current_grant !== 3'd4) begin errors++; $display("FAIL single_ptr_next: got %0d want 4", current_grant); end
    checks++; if (rdy_vec() !== 5'b10000) begin errors++; $display("FAIL single_ptr_tready: got %b want 10000", rdy_vec()); end
    step();
    in_mosi[4] = '0;
    #1;
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL single_ptr_bubble: got %b want 0", grant_valid); end
    step();
    checks++; if (current_grant !== 3'd1 || grant_valid !== 1'b1) begin
      errors++; $display("FAIL single_ptr_second: got %0d/%b want 1/1", current_grant, grant_valid); end
    step();
    in_mosi[1] = '0;
  endtask

  task automatic test_round_robin();
    int ch;
    axis_mosi_t exp;
    apply_reset();
    for (int i = 0; i < NCH; i++) in_mosi[i] = beat(i, 0, 1'b0);
    #1;
    for (int p = 0; p < 6; p++) begin
      ch = p % NCH;
      step();
      exp = beat(ch, 0, 1'b0);
      checks++; if (current_grant !== GW'(ch) || grant_valid !== 1'b1) begin
        errors++; $display("FAIL rr_order%0d: got %0d/%b want %0d/1", p, current_grant, grant_valid, ch); end
      checks++; if (out_mosi !== exp) begin errors++; $display("FAIL rr_hdr%0d: got %h want %h", p, out_mosi, exp); end
      step();
      exp = beat(ch, 1, 1'b1);
      in_mosi[ch] = exp;
      #1;
      checks++; if (out_mosi !== exp) begin errors++; $display("FAIL rr_last%0d: got %h want %h", p, out_mosi, exp); end
      checks++; if (rdy_vec() !== NCH'(1 << ch)) begin
        errors++; $display("FAIL rr_tready%0d: got %b want %b", p, rdy_vec(), NCH'(1 << ch)); end
      step();
      in_mosi[ch] = beat(ch, 0, 1'b0);
      #1;
      checks++; if (grant_valid !== 1'b0 || out_mosi !== '0) begin
        errors++; $display("FAIL rr_bubble%0d: got %b/%h want 0/0", p, grant_valid, out_mosi); end
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    axis_mosi_t exp;
    apply_reset();
    out_miso.tready = 1'b1;
    in_mosi[1] = beat(1, 0, 1'b0);
    step();
    checks++; if (current_grant !== 3'd1 || rdy_vec() !== 5'b00010) begin
      errors++; $display("FAIL bp_lock: got %0d/%b want 1/00010", current_grant, rdy_vec()); end
    step();
    exp = beat(1, 1, 1'b0);
    in_mosi[1] = exp;
    in_mosi[3] = beat(3, 0, 1'b1);
    out_miso.tready = 1'b0;
    #1;
    checks++; if (out_mosi !== exp || rdy_vec() !== '0) begin
      errors++; $display("FAIL bp_stall0: got %h/%b want %h/00000", out_mosi, rdy_vec(), exp); end
    step();
    checks++; if (out_mosi !== exp || current_grant !== 3'd1) begin
      errors++; $display("FAIL bp_stall1: got %h/%0d want %h/1", out_mosi, current_grant, exp); end
    step();
    checks++; if (out_mosi !== exp || grant_valid !== 1'b1) begin
      errors++; $display("FAIL bp_stall2: got %h/%b want %h/1", out_mosi, grant_valid, exp); end
    out_miso.tready = 1'b1;
    #1;
    checks++; if (rdy_vec() !== 5'b00010) begin errors++; $display("FAIL bp_resume: got %b want 00010", rdy_vec()); end
    step();
    exp = beat(1, 2, 1'b1);
    in_mosi[1] = exp;
    out_miso.tready = 1'b0;
    step();
    checks++; if (current_grant !== 3'd1 || grant_valid !== 1'b1 || out_mosi !== exp) begin
      errors++; $display("FAIL bp_last_held: got %0d/%b/%h want 1/1/%h", current_grant, grant_valid, out_mosi, exp); end
    out_miso.tready = 1'b1;
    step();
    in_mosi[1] = '0;
    #1;
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b want 0", grant_valid); end
    step();
    exp = beat(3, 0, 1'b1);
    checks++; if (current_grant !== 3'd3 || out_mosi !== exp) begin
      errors++; $display("FAIL bp_next_grant: got %0d/%h want 3/%h", current_grant, out_mosi, exp); end
    step();
    in_mosi[3] = '0;
  endtask

  task automatic test_wrap();
    apply_reset();
    in_mosi[3] = beat(3, 0, 1'b1);
    step();
    checks++; if (current_grant !== 3'd3) begin errors++; $display("FAIL wrap_first: got %0d want 3", current_grant); end
    step();
    in_mosi[3] = '0;
    in_mosi[0] = beat(0, 0, 1'b1);
    in_mosi[4] = beat(4, 0, 1'b1);
    step();
    checks++; if (current_grant !== 3'd4) begin errors++; $display("FAIL wrap_four: got %0d want 4", current_grant); end
    step();
    in_mosi[4] = '0;
    step();
    checks++; if (current_grant !== 3'd0 || grant_valid !== 1'b1) begin
      errors++; $display("FAIL wrap_zero: got %0d/%b want 0/1", current_grant, grant_valid); end
    step();
    in_mosi[0] = '0;
  endtask

  task automatic test_proto_err();
    apply_reset();
    in_mosi[1] = beat(1, 1, 1'b0);
    #1;
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL perr_early: got %b want 0", proto_err); end
    step();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_set: got %b want 1", proto_err); end
    checks++; if (rdy_vec() !== '0 || grant_valid !== 1'b0) begin
      errors++; $display("FAIL perr_stalled: got %b/%b want 00000/0", rdy_vec(), grant_valid); end
    in_mosi[1] = '0;
    step();
    step();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %b want 1", proto_err); end
    apply_reset();
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL perr_cleared: got %b want 0", proto_err); end
  endtask

  task automatic test_reset_mid();
    axis_mosi_t exp;
    apply_reset();
    in_mosi[2] = beat(2, 0, 1'b0);
    step();
    step();
    in_mosi[2] = beat(2, 1, 1'b0);
    step();
    in_mosi[2] = beat(2, 2, 1'b0);
    #1;
    checks++; if (grant_valid !== 1'b1) begin errors++; $display("FAIL rmid_locked: got %b want 1", grant_valid); end
    rst_i = 1'b1;
    #1;
    checks++; if (grant_valid !== 1'b0 || current_grant !== '0 || out_mosi !== '0 || rdy_vec() !== '0) begin
      errors++; $display("FAIL rmid_async: got %b/%0d/%h/%b want 0/0/0/00000",
                         grant_valid, current_grant, out_mosi, rdy_vec()); end
    in_mosi[2] = '0;
    rst_i = 1'b0;
    exp = beat(0, 0, 1'b1);
    in_mosi[0] = exp;
    step();
    checks++; if (grant_valid !== 1'b1 || current_grant !== 3'd0 || out_mosi !== exp) begin
      errors++; $display("FAIL rmid_regrant: got %b/%0d/%h want 1/0/%h", grant_valid, current_grant, out_mosi, exp); end
    step();
    in_mosi[0] = '0;
    #1;
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b want 0", grant_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_proto_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
